rob_commit_unit: RTL and testbench

- In-order reorder buffer for the Tomasulo RISC-V core.
- Allocates a ROB tag per dispatched instruction and captures results broadcast on the CDB.
- Retires the head entry, at most one per cycle, driving the register-file commit port: commit_valid, commit_value, commit_rd, commit_tag.
- On a mispredicted branch at head, commits it and then raises rollback_signal to flush the machine.

---
 rtl/rob_if.sv | 46 ++++
 rtl/rob_commit_unit.sv | 178 +++++++++++++++++
 tb/tb_rob_commit_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rob_if.sv
// Dispatcher / CDB / register-file side of the reorder buffer.
// The ROB sits on the slave modport; the environment drives through master.
interface rob_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  logic              alloc_valid;
  logic              alloc_has_rd;
  logic [4:0]        alloc_rd;
  logic              alloc_is_branch;
  logic [TAG_W-1:0]  alloc_tag;
  logic              rob_full;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              cdb_mispredict;
  logic [31:0]       cdb_target_pc;

  logic [TAG_W-1:0]  qry1_tag, qry2_tag;
  logic              qry1_ready, qry2_ready;
  logic [DATA_W-1:0] qry1_value, qry2_value;

  logic              commit_valid;
  logic [DATA_W-1:0] commit_value;
  logic [4:0]        commit_rd;
  logic [TAG_W-1:0]  commit_tag;
  logic              rollback_signal;
  logic [31:0]       rollback_pc;

  modport master (
    output alloc_valid, alloc_has_rd, alloc_rd, alloc_is_branch,
    output cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target_pc,
    output qry1_tag, qry2_tag,
    input  alloc_tag, rob_full, qry1_ready, qry2_ready, qry1_value, qry2_value,
    input  commit_valid, commit_value, commit_rd, commit_tag, rollback_signal, rollback_pc
  );

  modport slave (
    input  alloc_valid, alloc_has_rd, alloc_rd, alloc_is_branch,
    input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target_pc,
    input  qry1_tag, qry2_tag,
    output alloc_tag, rob_full, qry1_ready, qry2_ready, qry1_value, qry2_value,
    output commit_valid, commit_value, commit_rd, commit_tag, rollback_signal, rollback_pc
  );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: tag allocation, CDB capture, single-entry retire
// and mispredict flush. Entry i carries tag i+1; tag 0 means "no producer".
module rob_entry #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              alloc,
  input  logic              free,
  input  logic              wb,
  input  logic              has_rd_d,
  input  logic [4:0]        rd_d,
  input  logic              is_br_d,
  input  logic [DATA_W-1:0] value_d,
  input  logic              mis_d,
  input  logic [31:0]       pc_d,
  output logic              busy,
  output logic              ready,
  output logic              has_rd,
  output logic [4:0]        rd,
  output logic              is_branch,
  output logic [DATA_W-1:0] value,
  output logic              mispredict,
  output logic [31:0]       target_pc
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      busy <= 1'b0; ready <= 1'b0; has_rd <= 1'b0; rd <= '0;
      is_branch <= 1'b0; value <= '0; mispredict <= 1'b0; target_pc <= '0;
    end else if (free) begin
      busy <= 1'b0; ready <= 1'b0;
    end else if (alloc) begin
      busy <= 1'b1; ready <= 1'b0; has_rd <= has_rd_d; rd <= rd_d;
      is_branch <= is_br_d; mispredict <= 1'b0;
    end else if (wb && busy) begin
      ready <= 1'b1; value <= value_d; mispredict <= mis_d; target_pc <= pc_d;
    end
  end
endmodule

module rob_commit_unit #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 5,
  parameter int DATA_W   = 32
) (
  input logic  clk,
  input logic  rst,
  input logic  rdy,
  rob_if.slave bus
);
  localparam int AW = $clog2(ROB_SIZE);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_n;

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   flush_pc;

  logic [ROB_SIZE-1:0]             e_busy, e_ready, e_has_rd, e_is_br, e_mis;
  logic [ROB_SIZE-1:0][4:0]        e_rd;
  logic [ROB_SIZE-1:0][DATA_W-1:0] e_value;
  logic [ROB_SIZE-1:0][31:0]       e_pc;

  logic              commit_valid, rollback_signal;
  logic [DATA_W-1:0] commit_value;
  logic [4:0]        commit_rd;
  logic [TAG_W-1:0]  commit_tag;
  logic [31:0]       rollback_pc;

  function automatic logic tag_ok(input logic [TAG_W-1:0] t);
    return (t != '0) && (t <= TAG_W'(ROB_SIZE));
  endfunction

  function automatic logic [AW-1:0] tag_idx(input logic [TAG_W-1:0] t);
    return AW'(t - TAG_W'(1));
  endfunction

  logic          rob_full, alloc_go, cdb_go, commit_go, do_flush, hit_head;
  logic          head_rdy, head_mis;
  logic [AW-1:0] cdb_idx, q1_idx, q2_idx;
  logic [DATA_W-1:0] head_val;
  logic [31:0]   head_pc;

  assign rob_full = (count == CW'(ROB_SIZE));
  assign cdb_idx  = tag_idx(bus.cdb_tag);
  // Wrong-path traffic is dropped both while flushing and in the rollback cycle.
  assign alloc_go = rdy && bus.alloc_valid && !rob_full && state == RUN && !rollback_signal;
  assign cdb_go   = rdy && bus.cdb_valid && tag_ok(bus.cdb_tag) && state == RUN && !rollback_signal;
  assign do_flush = rdy && state == FLUSH;

  // A CDB hit on the head is forwarded so it retires on the same edge.
  assign hit_head  = cdb_go && cdb_idx == head && e_busy[head];
  assign head_rdy  = e_ready[head] || hit_head;
  assign head_val  = hit_head ? bus.cdb_value      : e_value[head];
  assign head_mis  = hit_head ? bus.cdb_mispredict : e_mis[head];
  assign head_pc   = hit_head ? bus.cdb_target_pc  : e_pc[head];
  assign commit_go = rdy && state == RUN && count != '0 && head_rdy;

  for (genvar i = 0; i < ROB_SIZE; i++) begin : g_ent
    rob_entry #(.DATA_W(DATA_W)) u_ent (
      .clk        (clk),
      .rst        (rst),
      .clr        (do_flush),
      .alloc      (alloc_go && tail == AW'(i)),
      .free       (commit_go && head == AW'(i)),
      .wb         (cdb_go && cdb_idx == AW'(i)),
      .has_rd_d   (bus.alloc_has_rd),
      .rd_d       (bus.alloc_rd),
      .is_br_d    (bus.alloc_is_branch),
      .value_d    (bus.cdb_value),
      .mis_d      (bus.cdb_mispredict),
      .pc_d       (bus.cdb_target_pc),
      .busy       (e_busy[i]),
      .ready      (e_ready[i]),
      .has_rd     (e_has_rd[i]),
      .rd         (e_rd[i]),
      .is_branch  (e_is_br[i]),
      .value      (e_value[i]),
      .mispredict (e_mis[i]),
      .target_pc  (e_pc[i])
    );
  end

  always_comb begin
    state_n = state;
    if (commit_go && e_is_br[head] && head_mis) state_n = FLUSH;
    else if (do_flush)                          state_n = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN; head <= '0; tail <= '0; count <= '0; flush_pc <= '0;
      commit_valid <= 1'b0; commit_value <= '0; commit_rd <= '0; commit_tag <= '0;
      rollback_signal <= 1'b0; rollback_pc <= '0;
    end else if (rdy) begin
      state           <= state_n;
      commit_valid    <= commit_go && e_has_rd[head];
      rollback_signal <= do_flush;
      if (commit_go) begin
        commit_rd    <= e_rd[head];
        commit_value <= head_val;
        commit_tag   <= TAG_W'(head) + TAG_W'(1);
      end
      if (commit_go && state_n == FLUSH) flush_pc <= head_pc;
      if (do_flush) begin
        rollback_pc <= flush_pc;
        head <= '0; tail <= '0; count <= '0;
      end else begin
        if (alloc_go)  tail <= tail + AW'(1);
        if (commit_go) head <= head + AW'(1);
        count <= count + CW'(alloc_go) - CW'(commit_go);
      end
    end
  end

  logic q1_byp, q2_byp;
  assign q1_idx = tag_idx(bus.qry1_tag);
  assign q2_idx = tag_idx(bus.qry2_tag);
  assign q1_byp = bus.cdb_valid && bus.cdb_tag == bus.qry1_tag;
  assign q2_byp = bus.cdb_valid && bus.cdb_tag == bus.qry2_tag;

  assign bus.qry1_ready = tag_ok(bus.qry1_tag) && (q1_byp || (e_busy[q1_idx] && e_ready[q1_idx]));
  assign bus.qry2_ready = tag_ok(bus.qry2_tag) && (q2_byp || (e_busy[q2_idx] && e_ready[q2_idx]));
  assign bus.qry1_value = q1_byp ? bus.cdb_value : e_value[q1_idx];
  assign bus.qry2_value = q2_byp ? bus.cdb_value : e_value[q2_idx];

  assign bus.alloc_tag       = TAG_W'(tail) + TAG_W'(1);
  assign bus.rob_full        = rob_full;
  assign bus.commit_valid    = commit_valid;
  assign bus.commit_value    = commit_value;
  assign bus.commit_rd       = commit_rd;
  assign bus.commit_tag      = commit_tag;
  assign bus.rollback_signal = rollback_signal;
  assign bus.rollback_pc     = rollback_pc;
endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit; commits and rollbacks are checked by a
// scoreboard monitor against expectations queued as stimulus is issued.
module tb_rob_commit_unit;
  logic clk = 1'b0;
  logic rst, rdy;
  int total = 0, bad = 0;

  rob_if #(.TAG_W(5), .DATA_W(32)) bus ();
  rob_commit_unit #(.ROB_SIZE(16), .TAG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [4:0]  tag;
  } commit_t;
  commit_t     exp_q[$];
  logic [31:0] rb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rdy) begin
      if (bus.commit_valid) begin
        if (exp_q.size() == 0) chk("commit_unexpected_tag", 32'(bus.commit_tag), 32'hffff_ffff);
        else begin
          commit_t e;
          e = exp_q.pop_front();
          chk("commit_rd", 32'(bus.commit_rd), 32'(e.rd));
          chk("commit_value", bus.commit_value, e.val);
          chk("commit_tag", 32'(bus.commit_tag), 32'(e.tag));
        end
      end
      if (bus.rollback_signal) begin
        if (rb_q.size() == 0) chk("rollback_unexpected", bus.rollback_pc, 32'hffff_ffff);
        else chk("rollback_pc", bus.rollback_pc, rb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic has_rd, input logic [4:0] rd, input logic br, input int exp_tag);
    chk("alloc_tag", 32'(bus.alloc_tag), 32'(exp_tag));
    bus.alloc_valid = 1'b1; bus.alloc_has_rd = has_rd; bus.alloc_rd = rd; bus.alloc_is_branch = br;
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val, input logic mis, input logic [31:0] pc);
    bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_value = val;
    bus.cdb_mispredict = mis; bus.cdb_target_pc = pc;
    step();
    bus.cdb_valid = 1'b0; bus.cdb_mispredict = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    bus.alloc_valid = 0; bus.alloc_has_rd = 0; bus.alloc_rd = 0; bus.alloc_is_branch = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0; bus.cdb_mispredict = 0; bus.cdb_target_pc = 0;
    bus.qry1_tag = 0; bus.qry2_tag = 0;
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_commit_valid", 32'(bus.commit_valid), 0);
    chk("rst_rollback", 32'(bus.rollback_signal), 0);
    chk("rst_commit_rd", 32'(bus.commit_rd), 0);
    chk("rst_rob_full", 32'(bus.rob_full), 0);
    chk("rst_alloc_tag", 32'(bus.alloc_tag), 1);
    bus.qry1_tag = 3; #1 chk("rst_qry1_ready_t3", 32'(bus.qry1_ready), 0);
    bus.qry1_tag = 0; #1 chk("rst_qry1_ready_t0", 32'(bus.qry1_ready), 0);

    // in-order retire with out-of-order results
    alloc(1, 5, 0, 1); exp_q.push_back('{5'd5, 32'h11, 5'd1});
    alloc(1, 6, 0, 2); exp_q.push_back('{5'd6, 32'h22, 5'd2});
    alloc(1, 7, 0, 3); exp_q.push_back('{5'd7, 32'h33, 5'd3});
    cdb(3, 32'h33, 0, 0);
    chk("order_no_commit_t3", 32'(bus.commit_valid), 0);
    bus.qry2_tag = 3; #1;
    chk("qry2_stored_ready", 32'(bus.qry2_ready), 1);
    chk("qry2_stored_value", bus.qry2_value, 32'h33);
    cdb(1, 32'h11, 0, 0);
    chk("order_commit_t1", 32'(bus.commit_valid), 1);
    step();
    chk("order_gap", 32'(bus.commit_valid), 0);
    cdb(2, 32'h22, 0, 0);
    chk("order_commit_t2", 32'(bus.commit_valid), 1);
    step();
    chk("order_commit_t3", 32'(bus.commit_valid), 1);
    step();
    chk("order_idle", 32'(bus.commit_valid), 0);
    chk("qry2_freed", 32'(bus.qry2_ready), 0);

    // CDB bypass on query
    alloc(1, 9, 0, 4); exp_q.push_back('{5'd9, 32'hABCD, 5'd4});
    bus.qry1_tag = 4; #1 chk("qry1_pending", 32'(bus.qry1_ready), 0);
    bus.cdb_valid = 1; bus.cdb_tag = 4; bus.cdb_value = 32'hABCD; #1;
    chk("qry1_bypass_ready", 32'(bus.qry1_ready), 1);
    chk("qry1_bypass_value", bus.qry1_value, 32'hABCD);
    step(); bus.cdb_valid = 0;
    chk("bypass_commit", 32'(bus.commit_valid), 1);
    step();

    // fill, overflow drop, wrap
    for (int k = 0; k < 16; k++) alloc(1, 10, 0, ((4 + k) % 16) + 1);
    chk("full_flag", 32'(bus.rob_full), 1);
    chk("full_alloc_tag", 32'(bus.alloc_tag), 5);
    alloc(1, 10, 0, 5);
    chk("full_drop_flag", 32'(bus.rob_full), 1);
    chk("full_drop_tag", 32'(bus.alloc_tag), 5);
    exp_q.push_back('{5'd10, 32'h55, 5'd5});
    bus.alloc_valid = 1;
    cdb(5, 32'h55, 0, 0);
    bus.alloc_valid = 0;
    chk("full_commit", 32'(bus.commit_valid), 1);
    chk("full_after_commit", 32'(bus.rob_full), 0);
    alloc(1, 10, 0, 5);
    chk("refull_flag", 32'(bus.rob_full), 1);
    chk("refull_tag", 32'(bus.alloc_tag), 6);

    // reset mid-operation
    rst = 1; step(); rst = 0;
    chk("midrst_full", 32'(bus.rob_full), 0);
    chk("midrst_tag", 32'(bus.alloc_tag), 1);
    chk("midrst_commit", 32'(bus.commit_valid), 0);
    bus.qry1_tag = 2; #1 chk("midrst_qry", 32'(bus.qry1_ready), 0);

    // mispredicted branch at head
    alloc(1, 2, 0, 1); exp_q.push_back('{5'd2, 32'h77, 5'd1});
    alloc(1, 1, 1, 2); exp_q.push_back('{5'd1, 32'h1004, 5'd2}); rb_q.push_back(32'h2000);
    alloc(1, 3, 0, 3);
    alloc(1, 4, 0, 4);
    alloc(1, 5, 0, 5);
    cdb(3, 32'h333, 0, 0);
    cdb(1, 32'h77, 0, 0);
    cdb(2, 32'h1004, 1, 32'h2000);
    chk("br_link_commit", 32'(bus.commit_valid), 1);
    chk("br_no_rb_yet", 32'(bus.rollback_signal), 0);
    cdb(4, 32'h444, 0, 0);
    chk("br_rollback", 32'(bus.rollback_signal), 1);
    chk("br_rollback_pc", bus.rollback_pc, 32'h2000);
    chk("br_commit_low", 32'(bus.commit_valid), 0);
    chk("br_tag_reset", 32'(bus.alloc_tag), 1);
    bus.alloc_valid = 1;
    cdb(1, 32'hdead, 0, 0);
    bus.alloc_valid = 0;
    chk("br_rb_drop", 32'(bus.rollback_signal), 0);
    chk("br_wrongpath_alloc", 32'(bus.alloc_tag), 1);
    chk("br_empty", 32'(bus.rob_full), 0);
    bus.qry1_tag = 1; #1 chk("br_wrongpath_cdb", 32'(bus.qry1_ready), 0);
    step(); step();

    // rdy freeze with a ready head
    alloc(0, 0, 0, 1);
    alloc(1, 8, 0, 2); exp_q.push_back('{5'd8, 32'h88, 5'd2});
    cdb(2, 32'h88, 0, 0);
    chk("rdy_pre_commit", 32'(bus.commit_valid), 0);
    cdb(1, 32'h11, 0, 0);
    chk("silent_retire", 32'(bus.commit_valid), 0);
    chk("silent_tag", 32'(bus.commit_tag), 1);
    rdy = 0; bus.alloc_valid = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("frz_commit", 32'(bus.commit_valid), 0);
      chk("frz_tag", 32'(bus.commit_tag), 1);
      chk("frz_alloc_tag", 32'(bus.alloc_tag), 3);
    end
    rdy = 1; bus.alloc_valid = 0;
    step();
    chk("rdy_resume_commit", 32'(bus.commit_valid), 1);
    step();
    chk("rdy_after", 32'(bus.commit_valid), 0);
    step(); step();

    chk("scoreboard_commits_left", 32'(exp_q.size()), 0);
    chk("scoreboard_rollbacks_left", 32'(rb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
